// File: rtl/multi_phase_timer.sv
// Bank of independent tick-driven countdown timers for the traffic phase sequencer.
// Each channel supports one-shot/auto-reload, pause and abort, with a one-cycle expiry pulse.
module multi_phase_timer #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         abort,
    input  logic [NUM_CH-1:0]         pause,
    input  logic [NUM_CH-1:0]         reload_en,
    input  logic [NUM_CH*WIDTH-1:0]   time_val,
    output logic [NUM_CH*WIDTH-1:0]   count_down,
    output logic [NUM_CH-1:0]         timer_exp,
    output logic [NUM_CH-1:0]         busy,
    output logic                      any_exp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [NUM_CH-1:0] exp_vec_d;
    logic              any_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           st_q, st_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] rl_q, rl_d;
        logic [WIDTH-1:0] tv;
        logic             exp_q, exp_d;

        assign tv = time_val[i*WIDTH +: WIDTH];

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            rl_d  = rl_q;
            exp_d = 1'b0;
            if (abort[i]) begin
                st_d  = IDLE;
                cnt_d = '0;
            end else if (start[i]) begin
                rl_d = tv;
                if (tv == '0) begin
                    exp_d = 1'b1;
                    cnt_d = '0;
                    st_d  = reload_en[i] ? RUN : IDLE;
                end else begin
                    cnt_d = tv;
                    st_d  = RUN;
                end
            end else begin
                unique case (st_q)
                    IDLE: cnt_d = '0;
                    RUN, PAUSE: begin
                        if (pause[i]) begin
                            st_d = PAUSE;
                        end else begin
                            st_d = RUN;
                            // A zero-length reload period is still RUN at count 0: expire every cycle.
                            if (cnt_q == '0 || (tick && cnt_q == WIDTH'(1))) begin
                                exp_d = 1'b1;
                                if (reload_en[i]) begin
                                    cnt_d = rl_q;
                                end else begin
                                    cnt_d = '0;
                                    st_d  = IDLE;
                                end
                            end else if (tick) begin
                                cnt_d = cnt_q - WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        st_d  = IDLE;
                        cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge sys_clk) begin
            if (reset) begin
                st_q  <= IDLE;
                cnt_q <= '0;
                rl_q  <= '0;
                exp_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                rl_q  <= rl_d;
                exp_q <= exp_d;
            end
        end

        assign count_down[i*WIDTH +: WIDTH] = cnt_q;
        assign timer_exp[i] = exp_q;
        assign busy[i]      = (st_q != IDLE);
        assign exp_vec_d[i] = exp_d;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) any_q <= 1'b0;
        else       any_q <= |exp_vec_d;
    end

    assign any_exp = any_q;

endmodule
